hit_scheduler: RTL and testbench

Round and damage controller for the cat-vs-dog health bar datapath. Takes raw collision requests from the projectile and sprite logic and sequences the game round. Converts requests into rate-limited single-cycle `hit_cat`/`hit_dog` pulses with per-player invulnerability windows measured in frames. Watches the health values returned by the health bar block to declare a winner.

---
 rtl/hit_scheduler.sv | 175 +++++++++++++++++
 tb/tb_hit_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_scheduler.sv
// hit_scheduler: round sequencing and rate-limited damage pulses for the cat-vs-dog health bars.
// Collision requests become single-cycle hit pulses, each followed by a per-player
// invulnerability window counted in frames. The health values fed back from the health bar
// block decide the winner.
// Optional feature: define HIT_FLASH_EN to blink the sprite of a player while that player
// is invulnerable. When it is undefined, flash_cat/flash_dog are tied low.

module hit_scheduler #(
  parameter int unsigned INVULN_FRAMES = 30,
  parameter int unsigned HP_W          = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            start,
  input  logic            cat_hit_req,
  input  logic            dog_hit_req,
  input  logic [HP_W-1:0] hp_cat,
  input  logic [HP_W-1:0] hp_dog,
  output logic            hit_cat,
  output logic            hit_dog,
  output logic            round_rst,
  output logic            playing,
  output logic [1:0]      winner,
  output logic            flash_cat,
  output logic            flash_dog
);

  localparam int unsigned CdW = $clog2(INVULN_FRAMES + 1);
  localparam logic [CdW-1:0] CdLoad = CdW'(INVULN_FRAMES);
  localparam logic [CdW-1:0] CdZero = '0;
  localparam logic [CdW-1:0] CdOne  = CdW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StPlay,
    StOver
  } state_e;

  state_e state_q, state_d;

  logic [CdW-1:0] cd_cat_q, cd_cat_d;
  logic [CdW-1:0] cd_dog_q, cd_dog_d;
  logic           hit_cat_q, hit_cat_d;
  logic           hit_dog_q, hit_dog_d;
  logic           round_rst_q, round_rst_d;
  logic [1:0]     winner_q, winner_d;

  logic cat_dead;
  logic dog_dead;
  logic round_end;
  logic hit_window;
  logic cd_clear;

  // Cooldown next value: clear beats load, load beats the frame decrement, and it
  // saturates at zero.
  function automatic logic [CdW-1:0] cd_next(input logic [CdW-1:0] cur,
                                             input logic           clear,
                                             input logic           load,
                                             input logic           tick);
    logic [CdW-1:0] nxt;
    nxt = cur;
    if (clear) begin
      nxt = CdZero;
    end else if (load) begin
      nxt = CdLoad;
    end else if (tick && (cur != CdZero)) begin
      nxt = cur - CdOne;
    end
    return nxt;
  endfunction

  assign cat_dead  = (hp_cat == '0);
  assign dog_dead  = (hp_dog == '0);
  assign round_end = (state_q == StPlay) && (cat_dead || dog_dead);

  // Hits are only issued in PLAY, and never on the edge that ends the round.
  assign hit_window = (state_q == StPlay) && !round_end;

  // Cooldowns are held clear for the whole of ARM, including the entry edge.
  assign cd_clear = (state_q == StArm) || (state_d == StArm);

  // Round sequencing: next state, round_rst pulse and winner capture.
  always_comb begin
    state_d     = state_q;
    round_rst_d = 1'b0;
    winner_d    = winner_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d     = StArm;
          round_rst_d = 1'b1;
          winner_d    = 2'b00;
        end
      end
      StArm: begin
        // Any tick seen in ARM counts; a tick on the entry edge was sampled in IDLE/OVER.
        if (frame_tick) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (round_end) begin
          state_d  = StOver;
          // MSB set when the cat is out (dog wins), LSB set when the dog is out.
          winner_d = {cat_dead, dog_dead};
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Hit pulses and invulnerability cooldowns for both players.
  always_comb begin
    hit_cat_d = hit_window && cat_hit_req && (cd_cat_q == CdZero);
    hit_dog_d = hit_window && dog_hit_req && (cd_dog_q == CdZero);
    cd_cat_d  = cd_next(cd_cat_q, cd_clear, hit_cat_d, frame_tick);
    cd_dog_d  = cd_next(cd_dog_q, cd_clear, hit_dog_d, frame_tick);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cd_cat_q    <= CdZero;
      cd_dog_q    <= CdZero;
      hit_cat_q   <= 1'b0;
      hit_dog_q   <= 1'b0;
      round_rst_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cd_cat_q    <= cd_cat_d;
      cd_dog_q    <= cd_dog_d;
      hit_cat_q   <= hit_cat_d;
      hit_dog_q   <= hit_dog_d;
      round_rst_q <= round_rst_d;
      winner_q    <= winner_d;
    end
  end

  assign hit_cat   = hit_cat_q;
  assign hit_dog   = hit_dog_q;
  assign round_rst = round_rst_q;
  assign playing   = (state_q == StPlay);
  assign winner    = winner_q;

`ifdef HIT_FLASH_EN
  logic [2:0] frame_cnt_q, frame_cnt_d;

  // Free-running frame counter; bit 2 gives a 4-frame on/off blink phase.
  always_comb begin
    frame_cnt_d = frame_tick ? frame_cnt_q + 3'd1 : frame_cnt_q;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 3'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign flash_cat = (cd_cat_q != CdZero) && !frame_cnt_q[2];
  assign flash_dog = (cd_dog_q != CdZero) && !frame_cnt_q[2];
`else
  assign flash_cat = 1'b0;
  assign flash_dog = 1'b0;
`endif

endmodule

// File: tb/tb_hit_scheduler.sv
// Self-checking bench for hit_scheduler: directed scenarios followed by random stimulus,
// scored against a behavioural model of the round/hit rules.

module tb_hit_scheduler;

  localparam int unsigned InvulnFrames = 3;
  localparam int unsigned HpW          = 10;

  localparam int PhIdle = 0;
  localparam int PhArm  = 1;
  localparam int PhPlay = 2;
  localparam int PhOver = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           frame_tick = 1'b0;
  logic           start = 1'b0;
  logic           cat_hit_req = 1'b0;
  logic           dog_hit_req = 1'b0;
  logic [HpW-1:0] hp_cat = 10'd500;
  logic [HpW-1:0] hp_dog = 10'd500;
  logic           hit_cat, hit_dog, round_rst, playing, flash_cat, flash_dog;
  logic [1:0]     winner;

  always #5 clk = ~clk;

  hit_scheduler #(
    .INVULN_FRAMES(InvulnFrames),
    .HP_W         (HpW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .cat_hit_req(cat_hit_req),
    .dog_hit_req(dog_hit_req),
    .hp_cat     (hp_cat),
    .hp_dog     (hp_dog),
    .hit_cat    (hit_cat),
    .hit_dog    (hit_dog),
    .round_rst  (round_rst),
    .playing    (playing),
    .winner     (winner),
    .flash_cat  (flash_cat),
    .flash_dog  (flash_dog)
  );

  typedef struct {
    logic       playing;
    logic [1:0] winner;
    logic       round_rst;
    logic       flash_cat;
    logic       flash_dog;
  } status_t;

  typedef struct {
    int   cyc;
    logic cat;
    logic dog;
  } hit_t;

  status_t stat_q[$];
  hit_t    hit_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cat_pulses = 0;
  int dog_pulses = 0;

  // Reference model state.
  int m_phase = PhIdle;
  int m_cd_cat = 0;
  int m_cd_dog = 0;
  int m_win = 0;
  int m_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_flash(input int cd);
`ifdef HIT_FLASH_EN
    return (cd != 0) && (m_frames < 4);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_status(input logic rr);
    status_t s;
    s.playing   = (m_phase == PhPlay);
    s.winner    = 2'(m_win);
    s.round_rst = rr;
    s.flash_cat = exp_flash(m_cd_cat);
    s.flash_dog = exp_flash(m_cd_dog);
    stat_q.push_back(s);
  endtask

  task automatic model_reset();
    m_phase  = PhIdle;
    m_cd_cat = 0;
    m_cd_dog = 0;
    m_win    = 0;
    m_frames = 0;
  endtask

  // Apply the game rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    int   ph_next;
    logic rr, hc, hd;
    bit   cat0, dog0;
    hit_t h;
    rr = 1'b0;
    hc = 1'b0;
    hd = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      ph_next = m_phase;
      cat0 = (hp_cat == 0);
      dog0 = (hp_dog == 0);
      case (m_phase)
        PhIdle, PhOver: if (start) begin
          ph_next = PhArm;
          rr      = 1'b1;
          m_win   = 0;
        end
        PhArm: if (frame_tick) ph_next = PhPlay;
        PhPlay: begin
          if (cat0 || dog0) begin
            ph_next = PhOver;
            m_win   = (cat0 && dog0) ? 3 : (cat0 ? 2 : 1);
          end else begin
            hc = cat_hit_req && (m_cd_cat == 0);
            hd = dog_hit_req && (m_cd_dog == 0);
          end
        end
        default: ph_next = PhIdle;
      endcase
      if (m_phase == PhArm || ph_next == PhArm) begin
        m_cd_cat = 0;
        m_cd_dog = 0;
      end else begin
        if (hc) m_cd_cat = InvulnFrames;
        else if (frame_tick && m_cd_cat > 0) m_cd_cat--;
        if (hd) m_cd_dog = InvulnFrames;
        else if (frame_tick && m_cd_dog > 0) m_cd_dog--;
      end
      if (frame_tick) m_frames = (m_frames + 1) % 8;
      m_phase = ph_next;
    end
    if (hc || hd) begin
      h.cyc = cyc;
      h.cat = hc;
      h.dog = hd;
      hit_q.push_back(h);
    end
    push_status(rr);
  endtask

  // One clock: model follows the edge, new inputs may be driven on return.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hit_cat"}, 32'(hit_cat), 0);
    chk({tag, "_hit_dog"}, 32'(hit_dog), 0);
    chk({tag, "_round_rst"}, 32'(round_rst), 0);
    chk({tag, "_playing"}, 32'(playing), 0);
    chk({tag, "_winner"}, 32'(winner), 0);
    chk({tag, "_flash_cat"}, 32'(flash_cat), 0);
    chk({tag, "_flash_dog"}, 32'(flash_dog), 0);
  endtask

  // Assert reset between clock edges, check it acts at once, hold it over two edges.
  task automatic async_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    stat_q.delete();
    hit_q.delete();
    model_reset();
    push_status(1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: pops the expected status every cycle and matches hit pulses to the scoreboard.
  status_t s_mon;
  hit_t    h_mon;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (stat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL status_queue (cycle %0d): got empty queue, expected an entry", cyc);
      end else begin
        s_mon = stat_q.pop_front();
        chk("playing", 32'(playing), 32'(s_mon.playing));
        chk("winner", 32'(winner), 32'(s_mon.winner));
        chk("round_rst", 32'(round_rst), 32'(s_mon.round_rst));
        chk("flash_cat", 32'(flash_cat), 32'(s_mon.flash_cat));
        chk("flash_dog", 32'(flash_dog), 32'(s_mon.flash_dog));
      end
    end
    while (hit_q.size() > 0 && hit_q[0].cyc < cyc) begin
      h_mon = hit_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_hit: got no pulse in cycle %0d, expected cat=%0d dog=%0d",
               h_mon.cyc, h_mon.cat, h_mon.dog);
    end
    if (hit_cat || hit_dog) begin
      if (hit_q.size() > 0 && hit_q[0].cyc == cyc) begin
        h_mon = hit_q.pop_front();
        chk("hit_cat", 32'(hit_cat), 32'(h_mon.cat));
        chk("hit_dog", 32'(hit_dog), 32'(h_mon.dog));
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit (cycle %0d): got cat=%0d dog=%0d, expected no pulse",
                 cyc, hit_cat, hit_dog);
      end
    end else if (hit_q.size() > 0 && hit_q[0].cyc == cyc) begin
      h_mon = hit_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_hit (cycle %0d): got no pulse, expected cat=%0d dog=%0d",
               cyc, h_mon.cat, h_mon.dog);
    end
    cat_pulses += int'(hit_cat);
    dog_pulses += int'(hit_dog);
  end

  initial begin
    int p0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // start and tick together in IDLE: the tick must not release ARM.
    start = 1'b1;
    frame_tick = 1'b1;
    step();
    start = 1'b0;
    frame_tick = 1'b0;
    step();
    step();
    tick();
    step();

    // Held cat request: one pulse over 100 cycles, a second after the cooldown expires.
    p0 = cat_pulses;
    cat_hit_req = 1'b1;
    repeat (100) step();
    chk("held_req_single_pulse", 32'(cat_pulses - p0), 1);
    repeat (3) begin
      tick();
      repeat (4) step();
    end
    chk("held_req_second_pulse", 32'(cat_pulses - p0), 2);
    cat_hit_req = 1'b0;

    // Let the cat cooldown run out, then simultaneous requests.
    repeat (3) tick();
    step();
    cat_hit_req = 1'b1;
    dog_hit_req = 1'b1;
    step();
    cat_hit_req = 1'b0;
    dog_hit_req = 1'b0;
    step();
    step();

    // Dog out: cat wins, later requests are ignored.
    hp_dog = 10'd0;
    hp_cat = 10'd200;
    step();
    hp_dog = 10'd500;
    step();
    repeat (4) tick();
    p0 = dog_pulses;
    dog_hit_req = 1'b1;
    repeat (10) step();
    dog_hit_req = 1'b0;
    chk("over_no_pulses", 32'(dog_pulses - p0), 0);

    // New round, then both out on the same cycle: draw.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    tick();
    step();
    hp_cat = 10'd0;
    hp_dog = 10'd0;
    step();
    hp_cat = 10'd500;
    hp_dog = 10'd500;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    tick();
    step();

    // Cooldown at 2 when reset hits mid-round.
    cat_hit_req = 1'b1;
    step();
    cat_hit_req = 1'b0;
    step();
    tick();
    step();
    async_reset_mid();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    tick();
    cat_hit_req = 1'b1;
    repeat (3) step();
    cat_hit_req = 1'b0;
    repeat (12) tick();

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      frame_tick  = ($urandom_range(0, 5) == 0);
      start       = ($urandom_range(0, 59) == 0);
      cat_hit_req = ($urandom_range(0, 2) == 0);
      dog_hit_req = ($urandom_range(0, 2) == 0);
      hp_cat      = HpW'($urandom_range(1, 1023));
      hp_dog      = HpW'($urandom_range(1, 1023));
      case ($urandom_range(0, 199))
        0, 1:    hp_cat = '0;
        2, 3:    hp_dog = '0;
        4:       begin hp_cat = '0; hp_dog = '0; end
        default: ;
      endcase
      step();
    end

    frame_tick  = 1'b0;
    start       = 1'b0;
    cat_hit_req = 1'b0;
    dog_hit_req = 1'b0;
    repeat (4) step();
    chk("hit_queue_drained", 32'(hit_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
